// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory: single-outstanding fetch port with configurable response latency
// and a side-band program-write port that always wins over fetch acceptance.
module instr_fetch_mem #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LATENCY   = 1,
  parameter bit          BYTE_ADDR = 1'b0,
  parameter string       INIT_FILE = "",
  localparam int unsigned PA_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_fault,
  input  logic              prog_we,
  input  logic [PA_W-1:0]   prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_err
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  // Counter reload so that WAIT lasts LATENCY-1 cycles before RESP.
  localparam logic [1:0] WaitLoad = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

  state_e            state;
  logic [1:0]        cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] pend_data;
  logic              pend_fault;

  logic [ADDR_W-1:0] word_idx;
  logic              fetch_fault;
  logic [DATA_W-1:0] fetch_word;
  logic              accept;
  logic              prog_ok;

  always_comb begin
    word_idx    = BYTE_ADDR ? (req_addr >> 2) : req_addr;
    fetch_fault = (64'(word_idx) >= 64'(DEPTH)) ||
                  (BYTE_ADDR && (req_addr[1:0] != 2'b00));
    // Faulted fetches never touch storage and return zero.
    fetch_word  = fetch_fault ? '0 : mem[word_idx[PA_W-1:0]];
  end

  assign req_ready = !reset && !prog_we &&
                     ((state == StIdle) || ((state == StResp) && rsp_ready));
  assign accept    = req_valid && req_ready;
  assign prog_ok   = prog_we && (32'(prog_addr) < DEPTH);

  // Storage has no reset; writes are suppressed while reset is high.
  always_ff @(posedge clk) begin
    if (!reset && prog_ok) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      cnt        <= 2'd0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_fault  <= 1'b0;
      pend_data  <= '0;
      pend_fault <= 1'b0;
      prog_err   <= 1'b0;
    end else begin
      prog_err <= prog_we && !prog_ok;
      if (accept) begin
        // Acceptance only happens from IDLE or from a retiring RESP.
        if (LATENCY == 1) begin
          state     <= StResp;
          rsp_valid <= 1'b1;
          rsp_data  <= fetch_word;
          rsp_fault <= fetch_fault;
        end else begin
          state      <= StWait;
          cnt        <= WaitLoad;
          pend_data  <= fetch_word;
          pend_fault <= fetch_fault;
          rsp_valid  <= 1'b0;
        end
      end else begin
        unique case (state)
          StWait: begin
            if (cnt == 2'd0) begin
              state     <= StResp;
              rsp_valid <= 1'b1;
              rsp_data  <= pend_data;
              rsp_fault <= pend_fault;
            end else begin
              cnt <= cnt - 2'd1;
            end
          end
          StResp: begin
            if (rsp_ready) begin
              state     <= StIdle;
              rsp_valid <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Bench for instr_fetch_mem: two configurations (LATENCY=1 byte-addressed, LATENCY=3 word-
// addressed non-power-of-2 depth) checked every cycle against a transaction-level model.
module tb_instr_fetch_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready, rsp_fault, prog_we, prog_err;
  logic [1:0][31:0] req_addr, rsp_data, prog_data;
  logic [1:0][9:0]  prog_addr;

  instr_fetch_mem #(
    .DATA_W(32), .DEPTH(1024), .ADDR_W(32), .LATENCY(1), .BYTE_ADDR(1'b1), .INIT_FILE("")
  ) u_lat1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_data(rsp_data[0]), .rsp_fault(rsp_fault[0]), .prog_we(prog_we[0]),
    .prog_addr(prog_addr[0]), .prog_data(prog_data[0]), .prog_err(prog_err[0])
  );

  instr_fetch_mem #(
    .DATA_W(32), .DEPTH(1000), .ADDR_W(32), .LATENCY(3), .BYTE_ADDR(1'b0), .INIT_FILE("")
  ) u_lat3 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_data(rsp_data[1]), .rsp_fault(rsp_fault[1]), .prog_we(prog_we[1]),
    .prog_addr(prog_addr[1]), .prog_data(prog_data[1]), .prog_err(prog_err[1])
  );

  // Per-lane configuration mirrored from the instance parameters above.
  int          lat [2] = '{1, 3};
  int          dep [2] = '{1024, 1000};
  bit          ba  [2] = '{1'b1, 1'b0};

  // Model: one outstanding transaction per lane, visible once enough edges have elapsed.
  logic [31:0] m_mem [2][1024];
  bit          m_out [2];
  int          m_acc [2];
  logic [31:0] m_dat [2];
  bit          m_flt [2];
  bit          m_perr [2];
  int          ecnt = 0;
  bit          chk_en = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] b2b_exp [4] = '{32'h08CA0052, 32'hA1A1A1A1, 32'h11223344, 32'hA3A3A3A3};

  task automatic chk(input string nm, input int l, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s lane%0d @%0t: got 0x%0h, expected 0x%0h", nm, l, $time, act, exp);
    end
  endtask

  function automatic bit m_vis(input int l);
    return m_out[l] && (ecnt >= m_acc[l] + lat[l] - 1);
  endfunction

  always @(posedge clk) begin
    bit     rdy;
    longint idx;
    for (int l = 0; l < 2; l++) begin
      rdy = !reset && !prog_we[l] && (!m_out[l] || (m_vis(l) && rsp_ready[l]));
      if (reset) begin
        m_out[l]  = 1'b0;
        m_perr[l] = 1'b0;
      end else begin
        if (m_vis(l) && rsp_ready[l]) m_out[l] = 1'b0;
        if (rdy && req_valid[l]) begin
          idx      = ba[l] ? longint'(req_addr[l] >> 2) : longint'(req_addr[l]);
          m_flt[l] = (idx >= dep[l]) || (ba[l] && (req_addr[l][1:0] != 2'b00));
          m_dat[l] = m_flt[l] ? 32'h0 : m_mem[l][idx];
          m_out[l] = 1'b1;
          m_acc[l] = ecnt + 1;
        end
        m_perr[l] = prog_we[l] && (int'(prog_addr[l]) >= dep[l]);
        if (prog_we[l] && (int'(prog_addr[l]) < dep[l])) m_mem[l][prog_addr[l]] = prog_data[l];
      end
    end
    ecnt = ecnt + 1;
  end

  always @(negedge clk) begin
    bit ev, er;
    if (chk_en) begin
      for (int l = 0; l < 2; l++) begin
        ev = m_vis(l);
        er = !reset && !prog_we[l] && (!m_out[l] || (ev && rsp_ready[l]));
        chk("rsp_valid", l, rsp_valid[l], ev);
        chk("req_ready", l, req_ready[l], er);
        chk("prog_err", l, prog_err[l], m_perr[l]);
        if (ev) begin
          chk("rsp_data", l, rsp_data[l], m_dat[l]);
          chk("rsp_fault", l, rsp_fault[l], m_flt[l]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input int l, input int a, input logic [31:0] d);
    prog_we[l]   = 1'b1;
    prog_addr[l] = 10'(a);
    prog_data[l] = d;
    tick();
    prog_we[l]   = 1'b0;
  endtask

  // Fetch with rsp_ready already high; checks the literal response at the expected cycle.
  task automatic fetch_lit(input int l, input logic [31:0] a, input logic [31:0] ed,
                           input bit ef);
    req_valid[l] = 1'b1;
    req_addr[l]  = a;
    tick();
    req_valid[l] = 1'b0;
    for (int k = 1; k < lat[l]; k++) begin
      @(negedge clk);
      chk("lit_wait_valid", l, rsp_valid[l], 1'b0);
      tick();
    end
    @(negedge clk);
    chk("lit_valid", l, rsp_valid[l], 1'b1);
    chk("lit_data", l, rsp_data[l], ed);
    chk("lit_fault", l, rsp_fault[l], ef);
    tick();
  endtask

  initial begin
    int          sel;
    int          word;
    reset     = 1'b1;
    req_valid = '0; rsp_ready = '0; prog_we = '0;
    req_addr  = '0; prog_addr = '0; prog_data = '0;
    tick();
    tick();
    @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      chk("reset_rsp_valid", l, rsp_valid[l], 1'b0);
      chk("reset_rsp_data", l, rsp_data[l], 32'h0);
      chk("reset_rsp_fault", l, rsp_fault[l], 1'b0);
      chk("reset_prog_err", l, prog_err[l], 1'b0);
      chk("reset_req_ready", l, req_ready[l], 1'b0);
    end
    reset  = 1'b0;
    chk_en = 1'b1;
    tick();

    // Fill both memories so every fetch has a defined expectation.
    for (int i = 0; i < 1024; i++) begin
      prog_we[0]   = 1'b1;
      prog_we[1]   = (i < 1000);
      prog_addr[0] = 10'(i);
      prog_addr[1] = 10'(i);
      prog_data[0] = $urandom;
      prog_data[1] = $urandom;
      tick();
    end
    prog_we = '0;

    // Lane 0: LATENCY=1, byte addressing.
    prog(0, 0, 32'h08CA0052);
    prog(0, 1, 32'hA1A1A1A1);
    prog(0, 2, 32'h11223344);
    prog(0, 3, 32'hA3A3A3A3);
    prog(0, 4, 32'h44444444);
    rsp_ready[0] = 1'b1;
    fetch_lit(0, 32'h0, 32'h08CA0052, 1'b0);
    fetch_lit(0, 32'h6, 32'h0, 1'b1);
    fetch_lit(0, 32'h1000, 32'h0, 1'b1);
    fetch_lit(0, 32'h8, 32'h11223344, 1'b0);

    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h0;
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) req_addr[0] = 32'((k + 1) * 4);
      else req_valid[0] = 1'b0;
      @(negedge clk);
      chk("b2b_valid", 0, rsp_valid[0], 1'b1);
      chk("b2b_data", 0, rsp_data[0], b2b_exp[k]);
      if (k < 3) chk("b2b_ready", 0, req_ready[0], 1'b1);
      tick();
    end

    // Write behind an in-flight fetch must not change its response.
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h10;
    tick();
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b0;
    prog_we[0]   = 1'b1;
    prog_addr[0] = 10'd4;
    prog_data[0] = 32'hDEADBEEF;
    @(negedge clk);
    chk("old_data", 0, rsp_data[0], 32'h44444444);
    tick();
    prog_we[0]   = 1'b0;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("old_data_held", 0, rsp_data[0], 32'h44444444);
    tick();
    prog_we[0]   = 1'b1;
    prog_addr[0] = 10'd9;
    prog_data[0] = 32'h99;
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h10;
    @(negedge clk);
    chk("prog_priority", 0, req_ready[0], 1'b0);
    tick();
    prog_we[0] = 1'b0;
    fetch_lit(0, 32'h10, 32'hDEADBEEF, 1'b0);

    // Lane 1: LATENCY=3, DEPTH=1000.
    prog(1, 5, 32'h19060002);
    req_valid[1] = 1'b1;
    req_addr[1]  = 32'd5;
    rsp_ready[1] = 1'b0;
    tick();
    req_valid[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("lat3_valid", 1, rsp_valid[1], (k >= 2) ? 1'b1 : 1'b0);
      if (k >= 2) chk("lat3_data", 1, rsp_data[1], 32'h19060002);
      if (k < 4) tick();
    end
    rsp_ready[1] = 1'b1;
    tick();
    @(negedge clk);
    chk("lat3_retired", 1, rsp_valid[1], 1'b0);
    tick();

    prog_we[1]   = 1'b1;
    prog_addr[1] = 10'd1000;
    prog_data[1] = 32'hFFFFFFFF;
    tick();
    prog_we[1] = 1'b0;
    @(negedge clk);
    chk("prog_err_pulse", 1, prog_err[1], 1'b1);
    tick();
    @(negedge clk);
    chk("prog_err_clear", 1, prog_err[1], 1'b0);
    fetch_lit(1, 32'd1000, 32'h0, 1'b1);

    // Reset while WAITing discards the fetch; prog_we during reset is ignored.
    req_valid[1] = 1'b1;
    req_addr[1]  = 32'd5;
    tick();
    req_valid[1] = 1'b0;
    reset        = 1'b1;
    prog_we[1]   = 1'b1;
    prog_addr[1] = 10'd5;
    prog_data[1] = 32'h0;
    @(negedge clk);
    chk("wait_no_valid", 1, rsp_valid[1], 1'b0);
    tick();
    reset      = 1'b0;
    prog_we[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("reset_discard", 1, rsp_valid[1], 1'b0);
      if (k == 0) chk("reset_idle_ready", 1, req_ready[1], 1'b1);
      tick();
    end
    fetch_lit(1, 32'd5, 32'h19060002, 1'b0);

    // Randomised traffic on both lanes.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      reset = ($urandom_range(0, 299) == 0);
      for (int l = 0; l < 2; l++) begin
        req_valid[l] = ($urandom_range(0, 9) < 6);
        rsp_ready[l] = ($urandom_range(0, 9) < 7);
        sel  = $urandom_range(0, 9);
        word = $urandom_range(0, dep[l] - 1);
        if (sel == 0) word = dep[l] + $urandom_range(0, 40);
        req_addr[l] = ba[l] ? 32'(word * 4 + ((sel == 1) ? $urandom_range(1, 3) : 0))
                            : 32'(word);
        if (sel == 2) req_addr[l] = $urandom;
        prog_we[l]   = ($urandom_range(0, 9) < 2);
        prog_addr[l] = ($urandom_range(0, 4) == 0) ? 10'($urandom_range(990, 1023))
                                                   : 10'($urandom_range(0, 1023));
        prog_data[l] = $urandom;
      end
      tick();
    end
    reset = 1'b0;
    req_valid = '0;
    prog_we = '0;
    tick();
    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_mem.md
INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 Parameter DATA_W, default 32, instruction word width in bits.
REQ-002 Parameter DEPTH, default 1024, number of instruction words stored.
REQ-003 Parameter ADDR_W, default 32, width of fetch address.
REQ-004 Parameter LATENCY, default 1, legal 1..4, cycles from request acceptance to rsp_valid.
REQ-005 Parameter BYTE_ADDR, default 0; 0 = req_addr is a word index, 1 = req_addr is a byte address, word index = req_addr >> 2.
REQ-006 Parameter INIT_FILE, default "" (empty), hex image loaded into storage at elaboration when non-empty; storage is otherwise unspecified.
REQ-007 Port clk  input  1  rising-edge clock for all state.
REQ-008 Port reset  input  1  synchronous, active-high reset.
REQ-009 Port req_valid  input  1  fetch request present.
REQ-010 Port req_ready  output  1  block accepts a fetch this cycle.
REQ-011 Port req_addr  input  ADDR_W  fetch address.
REQ-012 Port rsp_valid  output  1  fetch response present.
REQ-013 Port rsp_ready  input  1  consumer takes the response this cycle.
REQ-014 Port rsp_data  output  DATA_W  fetched instruction word.
REQ-015 Port rsp_fault  output  1  fetch address illegal; qualified by rsp_valid.
REQ-016 Port prog_we  input  1  program-write strobe.
REQ-017 Port prog_addr  input  clog2(DEPTH)  program-write word index.
REQ-018 Port prog_data  input  DATA_W  program-write data.
REQ-019 Port prog_err  output  1  one-cycle pulse: program write rejected.

Function
REQ-020 Single outstanding fetch; states IDLE, WAIT, RESP.
REQ-021 Request accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-022 req_ready = 1 in IDLE, or in RESP when rsp_ready=1; forced to 0 whenever prog_we=1 (program writes take priority).
REQ-023 On acceptance, word index, fault status and storage contents at that index are captured; later writes do not alter the in-flight response.
REQ-024 Fault conditions: word index >= DEPTH; or BYTE_ADDR=1 and req_addr[1:0] != 0.
REQ-025 Faulted fetch: rsp_fault=1, rsp_data=0, same latency as a legal fetch; storage not read.
REQ-026 Acceptance at edge N -> rsp_valid=1 from edge N+LATENCY; LATENCY=1 goes IDLE->RESP directly, otherwise IDLE->WAIT, counter counts LATENCY-1 cycles, WAIT->RESP.
REQ-027 In RESP, rsp_valid, rsp_data, rsp_fault held stable until edge with rsp_ready=1.
REQ-028 RESP with rsp_ready=1 and no new acceptance -> IDLE, rsp_valid=0 next cycle.
REQ-029 RESP with rsp_ready=1 and a new acceptance same edge -> response retired, new fetch started (WAIT or RESP per LATENCY); back-to-back throughput 1 fetch/cycle when LATENCY=1.
REQ-030 rsp_ready while rsp_valid=0 is ignored; req_valid while req_ready=0 is ignored (requester holds).
REQ-031 prog_we=1 with prog_addr < DEPTH writes prog_data at next edge; prog_err=0.
REQ-032 prog_we=1 with prog_addr >= DEPTH (non-power-of-2 DEPTH) -> no write, prog_err=1 for exactly the following cycle.
REQ-033 Program writes allowed in any state; they never disturb WAIT counter or RESP outputs.
REQ-034 Fetch address wrap: no wrap; out-of-range indices fault per REQ-024.

Reset
REQ-035 reset=1 at an edge -> state IDLE, counter 0, rsp_valid=0, rsp_data=0, rsp_fault=0, prog_err=0.
REQ-036 Reset mid-fetch (WAIT or RESP) discards the fetch; no response is ever produced for it.
REQ-037 Storage contents are not cleared by reset; prog_we during reset is ignored.
REQ-038 req_ready=0 while reset=1.

Verification
REQ-039 LATENCY=1, INIT mem[0]=0x08CA0052: req addr 0 at edge N -> rsp_valid=1, rsp_data=0x08CA0052, rsp_fault=0 at N+1.
REQ-040 LATENCY=3: prog write mem[5]=0x19060002, then fetch 5 with rsp_ready=0 for 4 cycles -> rsp_valid rises at N+3, data held constant until rsp_ready=1, then rsp_valid=0.
REQ-041 BYTE_ADDR=1: req_addr=0x6 -> rsp_fault=1, rsp_data=0; req_addr=0x1000 with DEPTH=1024 -> rsp_fault=1; req_addr=0x8 -> mem[2].
REQ-042 LATENCY=1, rsp_ready=1 held, req_valid=1 addresses 0,1,2,3 consecutive -> four responses on consecutive cycles, in order.
REQ-043 Fetch mem[4] accepted, prog write mem[4]=0xDEADBEEF next cycle -> response returns old mem[4]; next fetch of 4 returns 0xDEADBEEF; prog_we=1 same cycle as req_valid -> req_ready=0.
REQ-044 DEPTH=1000, prog_addr=1000 -> prog_err pulse 1 cycle, no write; reset in WAIT with LATENCY=4 -> rsp_valid stays 0, state IDLE next cycle.
